distortion_processor: RTL and testbench

Audio-path consumer of the distortion control settings (`gain`, `threshold`, `mode`) produced by the key/switch controller. It applies gain and one of three clipping characteristics to a stream of signed 16-bit samples. It sits between the codec sample receiver and the codec transmitter. The datapath is a 3-stage valid-qualified pipeline with a clip-indicator LED driven by a hold timer.

---
 rtl/distortion_pkg.sv | 21 ++
 rtl/distortion_if.sv | 24 ++
 rtl/clip_hold_timer.sv | 30 +++
 rtl/distortion_processor.sv | 126 ++++++++++++
 tb/tb_distortion_processor.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/distortion_pkg.sv
// Shared types and constants for the distortion audio path.
package distortion_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int THR_W  = 32;
    localparam int PROD_W = 32;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GAIN   = 2'd1,
        MODE_SOFT   = 2'd2,
        MODE_HARD   = 2'd3
    } dist_mode_t;

endpackage

// File: rtl/distortion_if.sv
// Sample stream plus control settings into the distortion processor, processed stream out.
interface distortion_if;
    import distortion_pkg::*;

    logic                      in_valid;
    sample_t                   in_data;
    logic signed [COEF_W-1:0]  gain;
    logic signed [THR_W-1:0]   threshold;
    dist_mode_t                mode;
    logic                      out_valid;
    sample_t                   out_data;
    logic                      clip_led;

    modport master (
        output in_valid, in_data, gain, threshold, mode,
        input  out_valid, out_data, clip_led
    );

    modport slave (
        input  in_valid, in_data, gain, threshold, mode,
        output out_valid, out_data, clip_led
    );

endinterface

// File: rtl/clip_hold_timer.sv
// Retriggerable hold timer: active for HOLD_CYCLES cycles after the most recent trigger.
module clip_hold_timer #(
    parameter int HOLD_CYCLES = 5_000_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic trigger,
    output logic active
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    // active drops one cycle after the count reaches zero, giving HOLD_CYCLES high cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (trigger) begin
            cnt    <= CNT_W'(HOLD_CYCLES - 1);
            active <= 1'b1;
        end else if (cnt != '0) begin
            cnt    <= cnt - CNT_W'(1);
        end else begin
            active <= 1'b0;
        end
    end

endmodule

// File: rtl/distortion_processor.sv
// Gain + clipping stage for signed 16-bit audio: capture, multiply, shape/saturate, clip LED.
module distortion_processor
    import distortion_pkg::*;
#(
    parameter int HOLD_CYCLES = 5_000_000,
    parameter int SOFT_SHIFT  = 3
) (
    input logic         CLK,
    input logic         RST_N,
    distortion_if.slave bus
);

    function automatic sample_t sat16(input logic signed [PROD_W-1:0] v);
        if (v > SAT_MAX) return sample_t'(SAT_MAX);
        if (v < SAT_MIN) return sample_t'(SAT_MIN);
        return v[DATA_W-1:0];
    endfunction

    function automatic logic overflows16(input logic signed [PROD_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [COEF_W-1:0] eff_gain(input logic signed [COEF_W-1:0] g);
        return (g < 1) ? COEF_W'(1) : g;
    endfunction

    function automatic sample_t eff_thr(input logic signed [THR_W-1:0] t);
        if (t < 1)       return sample_t'(1);
        if (t > SAT_MAX) return sample_t'(SAT_MAX);
        return t[DATA_W-1:0];
    endfunction

    sample_t                   data_p0;
    logic signed [COEF_W-1:0]  gain_p0;
    sample_t                   thr_p0, thr_p1;
    dist_mode_t                mode_p0, mode_p1;
    logic signed [PROD_W-1:0]  prod_p1;
    sample_t                   out_p2;
    logic                      clip_p2;
    logic                      vld_p0, vld_p1, vld_p2;

    logic signed [PROD_W-1:0]  mult;
    logic signed [PROD_W-1:0]  thr_ext, abs_p, soft_mag, soft_val;
    sample_t                   shaped;
    logic                      clip_n;
    logic                      led;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            out_p2 <= '0;
        end else begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) out_p2 <= shaped;
        end
    end

    // Stage 1: capture sample with its own control settings
    always_ff @(posedge CLK) begin
        if (bus.in_valid) begin
            data_p0 <= bus.in_data;
            gain_p0 <= eff_gain(bus.gain);
            thr_p0  <= eff_thr(bus.threshold);
            mode_p0 <= bus.mode;
        end
        if (vld_p0) begin
            prod_p1 <= mult;
            thr_p1  <= thr_p0;
            mode_p1 <= mode_p0;
        end
        if (vld_p1) clip_p2 <= clip_n;
    end

    // Stage 2: 16x16 product always fits in 32 bits
    always_comb begin
        mult = PROD_W'(data_p0);
        if (mode_p0 != MODE_BYPASS) mult = PROD_W'(data_p0) * PROD_W'(gain_p0);
    end

    // Stage 3: shape by mode, then saturate to 16 bits
    always_comb begin
        thr_ext  = PROD_W'(thr_p1);
        abs_p    = prod_p1[PROD_W-1] ? -prod_p1 : prod_p1;
        soft_mag = thr_ext + ((abs_p - thr_ext) >>> SOFT_SHIFT);
        soft_val = prod_p1[PROD_W-1] ? -soft_mag : soft_mag;
        shaped   = prod_p1[DATA_W-1:0];
        clip_n   = 1'b0;
        case (mode_p1)
            MODE_GAIN: begin
                shaped = sat16(prod_p1);
                clip_n = overflows16(prod_p1);
            end
            MODE_SOFT: begin
                if (abs_p > thr_ext) begin
                    shaped = sat16(soft_val);
                    clip_n = 1'b1;
                end
            end
            MODE_HARD: begin
                if (abs_p > thr_ext) begin
                    shaped = prod_p1[PROD_W-1] ? -thr_p1 : thr_p1;
                    clip_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    clip_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_clip_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .trigger (vld_p2 & clip_p2),
        .active  (led)
    );

    assign bus.out_valid = vld_p2;
    assign bus.out_data  = out_p2;
    assign bus.clip_led  = led;

endmodule

// File: tb/tb_distortion_processor.sv
// Directed bench for distortion_processor: vector table plus multi-cycle sequences.
module tb_distortion_processor;
    import distortion_pkg::*;

    localparam int HOLD = 10;

    logic CLK;
    logic RST_N;

    distortion_if bus ();

    distortion_processor #(
        .HOLD_CYCLES(HOLD),
        .SOFT_SHIFT (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         d;
        int         g;
        int         t;
        dist_mode_t m;
        int         exp;
        int         clip;
    } vec_t;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int d, input int g, input int t, input dist_mode_t m);
        bus.in_valid  = 1'b1;
        bus.in_data   = sample_t'(d);
        bus.gain      = COEF_W'(g);
        bus.threshold = t;
        bus.mode      = m;
    endtask

    // One sample: output exactly 3 edges after capture, LED state one edge later.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v.d, v.g, v.t, v.m);
        tick(1);
        bus.in_valid = 1'b0;
        tick(1);
        chk({tag, "_early_valid"}, int'(bus.out_valid), 0);
        tick(1);
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_data"}, int'(bus.out_data), v.exp);
        tick(1);
        chk({tag, "_valid_drop"}, int'(bus.out_valid), 0);
        chk({tag, "_led"}, int'(bus.clip_led), v.clip);
    endtask

    vec_t vecs[19];
    vec_t b2b[4];
    int   b2b_exp[4];

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{-5,     1,  1000,   MODE_BYPASS, -5,     0};
        vecs[1]  = '{1234,   50, 1000,   MODE_BYPASS, 1234,   0};
        vecs[2]  = '{-32768, 7,  1000,   MODE_BYPASS, -32768, 0};
        vecs[3]  = '{20000,  2,  1000,   MODE_GAIN,   32767,  1};
        vecs[4]  = '{-20000, 2,  1000,   MODE_GAIN,   -32768, 1};
        vecs[5]  = '{1000,   3,  1000,   MODE_GAIN,   3000,   0};
        vecs[6]  = '{7,      0,  1000,   MODE_GAIN,   7,      0};
        vecs[7]  = '{-9,     -3, 1000,   MODE_GAIN,   -9,     0};
        vecs[8]  = '{-32768, 1,  1000,   MODE_GAIN,   -32768, 0};
        vecs[9]  = '{-20000, 1,  16000,  MODE_HARD,   -16000, 1};
        vecs[10] = '{12000,  1,  16000,  MODE_HARD,   12000,  0};
        vecs[11] = '{30000,  2,  40000,  MODE_HARD,   32767,  1};
        vecs[12] = '{5,      1,  0,      MODE_HARD,   1,      1};
        vecs[13] = '{-5,     1,  -100,   MODE_HARD,   -1,     1};
        vecs[14] = '{1800,   1,  1000,   MODE_SOFT,   1100,   1};
        vecs[15] = '{-1800,  1,  1000,   MODE_SOFT,   -1100,  1};
        vecs[16] = '{900,    1,  1000,   MODE_SOFT,   900,    0};
        vecs[17] = '{1000,   1,  1000,   MODE_SOFT,   1000,   0};
        vecs[18] = '{30000,  50, 20,     MODE_SOFT,   32767,  1};

        b2b[0] = '{10000, 2,  16000, MODE_GAIN, 0, 0};
        b2b[1] = '{20000, 2,  16000, MODE_GAIN, 0, 0};
        b2b[2] = '{10000, 2,  16000, MODE_HARD, 0, 0};
        b2b[3] = '{-9000, -3, 16000, MODE_HARD, 0, 0};
        b2b_exp[0] = 20000;
        b2b_exp[1] = 32767;
        b2b_exp[2] = 16000;
        b2b_exp[3] = -9000;

        RST_N         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.gain      = COEF_W'(1);
        bus.threshold = 1000;
        bus.mode      = MODE_BYPASS;
        #3;
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_data", int'(bus.out_data), 0);
        chk("reset_led", int'(bus.clip_led), 0);
        tick(2);
        RST_N = 1'b1;
        tick(2);

        for (int i = 0; i < 19; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick(12);
        end

        // LED hold length after a single clip
        run_vec(vecs[3], "hold");
        for (int k = 1; k < HOLD; k++) begin
            tick(1);
            chk($sformatf("hold_high_%0d", k), int'(bus.clip_led), 1);
        end
        tick(1);
        chk("hold_low", int'(bus.clip_led), 0);
        tick(4);

        // Retrigger: second clip output 5 edges after the first extends the hold
        drive(20000, 2, 1000, MODE_GAIN);
        tick(1);
        bus.in_valid = 1'b0;
        tick(4);
        drive(-20000, 2, 1000, MODE_GAIN);
        tick(1);
        bus.in_valid = 1'b0;
        tick(8);
        chk("retrig_extended", int'(bus.clip_led), 1);
        tick(4);
        chk("retrig_last_high", int'(bus.clip_led), 1);
        tick(1);
        chk("retrig_low", int'(bus.clip_led), 0);
        tick(4);

        // Back-to-back samples with a mode change on the third
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(b2b[i].d, b2b[i].g, b2b[i].t, b2b[i].m);
            else bus.in_valid = 1'b0;
            tick(1);
            if (i + 1 < 3) begin
                chk($sformatf("b2b_idle_%0d", i), int'(bus.out_valid), 0);
            end else if (i + 1 <= 6) begin
                chk($sformatf("b2b_valid_%0d", i - 2), int'(bus.out_valid), 1);
                chk($sformatf("b2b_data_%0d", i - 2), int'(bus.out_data), b2b_exp[i - 2]);
            end else begin
                chk("b2b_end", int'(bus.out_valid), 0);
            end
        end
        tick(14);

        // Asynchronous reset with two samples in flight
        run_vec(vecs[3], "pre_rst");
        chk("pre_rst_data_held", int'(bus.out_data), 32767);
        drive(100, 1, 1000, MODE_GAIN);
        tick(1);
        drive(200, 1, 1000, MODE_GAIN);
        tick(1);
        bus.in_valid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_now_valid", int'(bus.out_valid), 0);
        chk("rst_now_data", int'(bus.out_data), 0);
        chk("rst_now_led", int'(bus.clip_led), 0);
        #2;
        RST_N = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk($sformatf("rst_flush_%0d", k), int'(bus.out_valid), 0);
            chk($sformatf("rst_led_%0d", k), int'(bus.clip_led), 0);
        end
        run_vec(vecs[5], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
